alu_req_arbiter: RTL and testbench

Round-robin command arbiter and sequencer that shares the signed ALU datapath (arithmetic, logic, compare and shift units) between two requesters. It accepts one operation at a time over a valid/ready handshake and drives the operands, function code and exactly one unit enable for a single cycle. It then waits for that unit's registered flag and returns the result to the granted requester over a valid/ready response channel. If no flag arrives within a bounded number of cycles, it reports a timeout error.

---
 rtl/alu_req_arbiter.sv | 133 +++++++++++++
 tb/tb_alu_req_arbiter.sv | 426 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_req_arbiter.sv
// Round-robin arbiter and sequencer sharing the ALU units between two requesters:
// accepts one operation, strobes one unit, waits for its flag (or times out), returns the result.
module alu_req_arbiter #(
    parameter int IN_WIDTH  = 16,
    parameter int OUT_WIDTH = 32,
    parameter int TIMEOUT   = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        req0_valid,
    output logic                        req0_ready,
    input  logic [3:0]                  req0_op,
    input  logic signed [IN_WIDTH-1:0]  req0_a,
    input  logic signed [IN_WIDTH-1:0]  req0_b,
    input  logic                        req1_valid,
    output logic                        req1_ready,
    input  logic [3:0]                  req1_op,
    input  logic signed [IN_WIDTH-1:0]  req1_a,
    input  logic signed [IN_WIDTH-1:0]  req1_b,
    output logic signed [IN_WIDTH-1:0]  a_out,
    output logic signed [IN_WIDTH-1:0]  b_out,
    output logic [1:0]                  alu_fun,
    output logic                        arith_enable,
    output logic                        logic_enable,
    output logic                        cmp_enable,
    output logic                        shift_enable,
    input  logic [OUT_WIDTH-1:0]        unit_result,
    input  logic                        unit_flag,
    output logic                        resp_valid,
    input  logic                        resp_ready,
    output logic                        resp_id,
    output logic [OUT_WIDTH-1:0]        resp_data,
    output logic                        resp_err
);

    localparam int CW = $clog2(TIMEOUT) + 1;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t                 state;
    logic                   last_grant;
    logic [CW-1:0]          wait_cnt;
    logic [3:0]             op_reg;
    logic [3:0]             enables;
    logic                   accept;
    logic                   sel;
    logic [3:0]             sel_op;
    logic signed [IN_WIDTH-1:0] sel_a;
    logic signed [IN_WIDTH-1:0] sel_b;

    // On a tie the requester that did not win last time gets the grant.
    always_comb begin
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        if (state == IDLE && !rst) begin
            if (req0_valid && req1_valid) begin
                req0_ready = last_grant;
                req1_ready = ~last_grant;
            end else begin
                req0_ready = req0_valid;
                req1_ready = req1_valid;
            end
        end
    end

    assign accept = (req0_valid & req0_ready) | (req1_valid & req1_ready);
    assign sel    = req1_valid & req1_ready;
    assign sel_op = sel ? req1_op : req0_op;
    assign sel_a  = sel ? req1_a  : req0_a;
    assign sel_b  = sel ? req1_b  : req0_b;

    assign alu_fun      = op_reg[1:0];
    assign arith_enable = enables[0];
    assign logic_enable = enables[1];
    assign cmp_enable   = enables[2];
    assign shift_enable = enables[3];
    assign resp_valid   = (state == RESP);

    // The unit strobe is loaded on acceptance so it is high only during ISSUE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            wait_cnt   <= '0;
            op_reg     <= '0;
            a_out      <= '0;
            b_out      <= '0;
            enables    <= '0;
            resp_id    <= 1'b0;
            resp_data  <= '0;
            resp_err   <= 1'b0;
        end else begin
            enables <= '0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        op_reg     <= sel_op;
                        a_out      <= sel_a;
                        b_out      <= sel_b;
                        resp_id    <= sel;
                        last_grant <= sel;
                        enables    <= 4'b0001 << sel_op[3:2];
                        state      <= ISSUE;
                    end
                end
                ISSUE: begin
                    wait_cnt <= '0;
                    state    <= WAIT;
                end
                WAIT: begin
                    if (unit_flag) begin
                        resp_data <= unit_result;
                        resp_err  <= 1'b0;
                        state     <= RESP;
                    end else if (wait_cnt == CW'(TIMEOUT - 1)) begin
                        resp_data <= '0;
                        resp_err  <= 1'b1;
                        state     <= RESP;
                    end else begin
                        wait_cnt <= wait_cnt + CW'(1);
                    end
                end
                RESP: begin
                    if (resp_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_req_arbiter.sv
// Bench for alu_req_arbiter: directed scenarios plus a randomized run checked
// against a transaction-level model of arbitration, latency and timeout.
module tb_alu_req_arbiter;

    localparam int TO = 4;

    logic               clk = 1'b0;
    logic               rst;
    logic               req0_valid, req1_valid;
    logic               req0_ready, req1_ready;
    logic [3:0]         req0_op, req1_op;
    logic signed [15:0] req0_a, req0_b, req1_a, req1_b;
    logic signed [15:0] a_out, b_out;
    logic [1:0]         alu_fun;
    logic               arith_enable, logic_enable, cmp_enable, shift_enable;
    logic [31:0]        unit_result;
    logic               unit_flag;
    logic               resp_valid, resp_ready, resp_id, resp_err;
    logic [31:0]        resp_data;

    int total = 0;
    int bad   = 0;
    bit model_last = 1'b1;

    wire [3:0] en = {shift_enable, cmp_enable, logic_enable, arith_enable};

    alu_req_arbiter #(.IN_WIDTH(16), .OUT_WIDTH(32), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
        .a_out(a_out), .b_out(b_out), .alu_fun(alu_fun),
        .arith_enable(arith_enable), .logic_enable(logic_enable), .cmp_enable(cmp_enable), .shift_enable(shift_enable),
        .unit_result(unit_result), .unit_flag(unit_flag),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
        .resp_data(resp_data), .resp_err(resp_err)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic idle_inputs();
        req0_valid = 0; req1_valid = 0; req0_op = 0; req1_op = 0;
        req0_a = 0; req0_b = 0; req1_a = 0; req1_b = 0;
        unit_flag = 0; unit_result = 0; resp_ready = 0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        req0_valid = 1; req1_valid = 1;
        repeat (2) @(negedge clk);
        #1;
        total++;
        if ({a_out, b_out, alu_fun, en, resp_valid, resp_id, resp_data, resp_err, req0_ready, req1_ready} !== 75'd0) begin
            bad++;
            $display("[TB] FAIL reset_outputs: got a=%h b=%h fun=%h en=%b rv=%b id=%b data=%h err=%b rdy=%b%b, want all zero",
                     a_out, b_out, alu_fun, en, resp_valid, resp_id, resp_data, resp_err, req0_ready, req1_ready);
        end
        rst = 1'b0;
        #1;
        total++;
        if ({req0_ready, req1_ready} !== 2'b10) begin
            bad++; $display("[TB] FAIL reset_first_tie: got %b want 10", {req0_ready, req1_ready});
        end
        req0_valid = 0; req1_valid = 0;
        @(negedge clk);
        req1_valid = 1;
        #1;
        total++;
        if ({req0_ready, req1_ready} !== 2'b01) begin
            bad++; $display("[TB] FAIL withdraw_then_req1: got %b want 01", {req0_ready, req1_ready});
        end
        req1_valid = 0;
        model_last = 1'b1;
    endtask

    task automatic test_single_compare();
        @(negedge clk);
        req0_valid = 1; req0_op = 4'b1010; req0_a = 16'sd5; req0_b = -16'sd3; resp_ready = 1;
        #1;
        total++;
        if ({req0_ready, req1_ready} !== 2'b10) begin
            bad++; $display("[TB] FAIL cmp_ready: got %b want 10", {req0_ready, req1_ready});
        end
        model_last = 1'b0;
        @(negedge clk);
        req0_valid = 0;
        #1;
        total++;
        if ({en, alu_fun, a_out, b_out, resp_valid} !== {4'b0100, 2'b10, 16'sd5, -16'sd3, 1'b0}) begin
            bad++; $display("[TB] FAIL cmp_issue: got en=%b fun=%b a=%0d b=%0d rv=%b want en=0100 fun=10 a=5 b=-3 rv=0",
                            en, alu_fun, a_out, b_out, resp_valid);
        end
        @(negedge clk);
        unit_flag = 1; unit_result = 32'd2;
        #1;
        total++;
        if ({en, resp_valid} !== 5'b0) begin
            bad++; $display("[TB] FAIL cmp_wait: got en=%b rv=%b want 0000 0", en, resp_valid);
        end
        @(negedge clk);
        unit_flag = 0;
        #1;
        total++;
        if ({resp_valid, resp_id, resp_err, resp_data} !== {3'b100, 32'd2}) begin
            bad++; $display("[TB] FAIL cmp_resp: got rv=%b id=%b err=%b data=%h want 1 0 0 2",
                            resp_valid, resp_id, resp_err, resp_data);
        end
        @(negedge clk);
        #1;
        total++;
        if (resp_valid !== 1'b0) begin
            bad++; $display("[TB] FAIL cmp_resp_drop: got %b want 0", resp_valid);
        end
        resp_ready = 0;
    endtask

    task automatic test_unit_decode();
        logic [3:0]  ops    [4] = '{4'h1, 4'h6, 4'hB, 4'hF};
        logic [3:0]  exp_en [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
        logic [1:0]  exp_fn [4] = '{2'd1, 2'd2, 2'd3, 2'd3};
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            req0_valid = 1; req0_op = ops[i]; req0_a = 16'(i); req0_b = 16'(i + 10); resp_ready = 1;
            #1;
            total++;
            if (req0_ready !== 1'b1) begin
                bad++; $display("[TB] FAIL decode_ready[%0d]: got %b want 1", i, req0_ready);
            end
            model_last = 1'b0;
            @(negedge clk);
            req0_valid = 0;
            #1;
            total++;
            if ({en, alu_fun} !== {exp_en[i], exp_fn[i]}) begin
                bad++; $display("[TB] FAIL decode_en[%0d]: got en=%b fun=%0d want en=%b fun=%0d",
                                i, en, alu_fun, exp_en[i], exp_fn[i]);
            end
            @(negedge clk);
            unit_flag = 1; unit_result = 32'(i * 7 + 1);
            #1;
            total++;
            if (en !== 4'b0000) begin
                bad++; $display("[TB] FAIL decode_en_off[%0d]: got %b want 0000", i, en);
            end
            @(negedge clk);
            unit_flag = 0;
            #1;
            total++;
            if ({resp_valid, resp_err, resp_data} !== {2'b10, 32'(i * 7 + 1)}) begin
                bad++; $display("[TB] FAIL decode_resp[%0d]: got rv=%b err=%b data=%0d want 1 0 %0d",
                                i, resp_valid, resp_err, resp_data, i * 7 + 1);
            end
        end
        resp_ready = 0;
    endtask

    task automatic test_contention();
        bit       prev_en = 0;
        bit       g = 0;
        logic [1:0] exp_rdy;
        logic [3:0] exp_en;
        @(negedge clk);
        rst = 1; #1; rst = 0;
        model_last = 1'b1;
        req0_op = 4'b0001; req1_op = 4'b1100;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            req0_valid = 1; req1_valid = 1; resp_ready = 1;
            unit_flag = prev_en; unit_result = 32'(k);
            #1;
            if (k % 4 == 0) begin
                g = ~model_last;
                model_last = g;
            end
            exp_rdy = (k % 4 == 0) ? (g ? 2'b01 : 2'b10) : 2'b00;
            exp_en  = (k % 4 == 1) ? (g ? 4'b1000 : 4'b0001) : 4'b0000;
            total++;
            if ({req0_ready, req1_ready, en} !== {exp_rdy, exp_en}) begin
                bad++; $display("[TB] FAIL contention_rdy_en[%0d]: got rdy=%b en=%b want rdy=%b en=%b",
                                k, {req0_ready, req1_ready}, en, exp_rdy, exp_en);
            end
            total++;
            if (resp_valid !== (k % 4 == 3) || (k % 4 == 3 && resp_id !== g)) begin
                bad++; $display("[TB] FAIL contention_resp[%0d]: got rv=%b id=%b want rv=%b id=%b",
                                k, resp_valid, resp_id, (k % 4 == 3), g);
            end
            prev_en = |en;
        end
        @(negedge clk);
        req0_valid = 0; req1_valid = 0; unit_flag = 0; resp_ready = 0;
    endtask

    task automatic test_timeout();
        for (int mode = 0; mode < 2; mode++) begin
            @(negedge clk);
            req1_valid = 1; req1_op = 4'b1101; req1_a = -16'sd9; req1_b = 16'sd2;
            resp_ready = 1; unit_flag = 0;
            #1;
            total++;
            if ({req0_ready, req1_ready} !== 2'b01) begin
                bad++; $display("[TB] FAIL timeout_ready[%0d]: got %b want 01", mode, {req0_ready, req1_ready});
            end
            model_last = 1'b1;
            for (int k = 1; k <= 2 + TO; k++) begin
                @(negedge clk);
                req1_valid = 0;
                unit_flag = (mode == 1 && k == 1 + TO);
                unit_result = 32'hABCD1234;
                #1;
                total++;
                if (resp_valid !== (k == 2 + TO)) begin
                    bad++; $display("[TB] FAIL timeout_rv[%0d] cycle %0d: got %b want %b", mode, k, resp_valid, (k == 2 + TO));
                end
                if (k == 2 + TO) begin
                    total++;
                    if ({resp_id, resp_err, resp_data} !== (mode == 1 ? {2'b10, 32'hABCD1234} : {2'b11, 32'h0})) begin
                        bad++; $display("[TB] FAIL timeout_fields[%0d]: got id=%b err=%b data=%h want id=1 err=%0d data=%h",
                                        mode, resp_id, resp_err, resp_data, mode == 0, mode == 1 ? 32'hABCD1234 : 32'h0);
                    end
                end
            end
            unit_flag = 0;
        end
        @(negedge clk);
        resp_ready = 0;
    endtask

    task automatic test_backpressure();
        @(negedge clk);
        req0_valid = 1; req0_op = 4'b0110; req0_a = 16'sd100; req0_b = -16'sd7; resp_ready = 0;
        #1;
        total++;
        if ({req0_ready, req1_ready} !== 2'b10) begin
            bad++; $display("[TB] FAIL bp_ready0: got %b want 10", {req0_ready, req1_ready});
        end
        model_last = 1'b0;
        @(negedge clk);
        req0_valid = 0;
        @(negedge clk);
        unit_flag = 1; unit_result = 32'h5A5A0001;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            unit_flag = 0; req1_valid = 1; req1_op = 4'b1000; req1_a = 16'sd1; req1_b = 16'sd2;
            #1;
            total++;
            if ({resp_valid, resp_id, resp_err, resp_data, req1_ready} !== {3'b100, 32'h5A5A0001, 1'b0}) begin
                bad++; $display("[TB] FAIL bp_hold[%0d]: got rv=%b id=%b err=%b data=%h r1=%b want 1 0 0 5a5a0001 0",
                                i, resp_valid, resp_id, resp_err, resp_data, req1_ready);
            end
        end
        @(negedge clk);
        resp_ready = 1;
        #1;
        total++;
        if ({resp_valid, req1_ready} !== 2'b10) begin
            bad++; $display("[TB] FAIL bp_release: got rv=%b r1=%b want 1 0", resp_valid, req1_ready);
        end
        @(negedge clk);
        #1;
        total++;
        if ({req0_ready, req1_ready} !== 2'b01) begin
            bad++; $display("[TB] FAIL bp_next_accept: got %b want 01", {req0_ready, req1_ready});
        end
        model_last = 1'b1;
        @(negedge clk);
        req1_valid = 0;
        #1;
        total++;
        if (en !== 4'b0100) begin
            bad++; $display("[TB] FAIL bp_req1_en: got %b want 0100", en);
        end
        @(negedge clk);
        unit_flag = 1; unit_result = 32'd77;
        @(negedge clk);
        unit_flag = 0;
        #1;
        total++;
        if ({resp_valid, resp_id, resp_err, resp_data} !== {3'b110, 32'd77}) begin
            bad++; $display("[TB] FAIL bp_req1_resp: got rv=%b id=%b err=%b data=%0d want 1 1 0 77",
                            resp_valid, resp_id, resp_err, resp_data);
        end
        @(negedge clk);
        resp_ready = 0;
    endtask

    task automatic test_reset_mid_wait();
        @(negedge clk);
        req0_valid = 1; req0_op = 4'b0010; req0_a = 16'sd3; req0_b = 16'sd4;
        #1;
        total++;
        if ({req0_ready, req1_ready} !== 2'b10) begin
            bad++; $display("[TB] FAIL rmw_ready: got %b want 10", {req0_ready, req1_ready});
        end
        @(negedge clk);
        req0_valid = 0;
        @(negedge clk);
        unit_flag = 1; unit_result = 32'd123; resp_ready = 1;
        #1;
        rst = 1;
        #1;
        total++;
        if ({a_out, b_out, alu_fun, en, resp_valid, resp_id, resp_data, resp_err, req0_ready, req1_ready} !== 75'd0) begin
            bad++; $display("[TB] FAIL rmw_async_clear: got a=%h b=%h fun=%h en=%b rv=%b id=%b data=%h err=%b want all zero",
                            a_out, b_out, alu_fun, en, resp_valid, resp_id, resp_data, resp_err);
        end
        @(negedge clk);
        unit_flag = 0;
        #1;
        total++;
        if (resp_valid !== 1'b0) begin
            bad++; $display("[TB] FAIL rmw_no_resp: got %b want 0", resp_valid);
        end
        @(negedge clk);
        req0_valid = 1; req1_valid = 1; rst = 0;
        #1;
        total++;
        if ({req0_ready, req1_ready} !== 2'b10) begin
            bad++; $display("[TB] FAIL rmw_tie_after_reset: got %b want 10", {req0_ready, req1_ready});
        end
        req0_valid = 0; req1_valid = 0;
        model_last = 1'b1;
        @(negedge clk);
        #1;
        total++;
        if ({resp_valid, en} !== 5'b0) begin
            bad++; $display("[TB] FAIL rmw_idle_after: got rv=%b en=%b want 0 0000", resp_valid, en);
        end
        resp_ready = 0;
    endtask

    // Transaction-level model: grant by round-robin, flag accepted within TO wait cycles,
    // response at acceptance + 2 + flag delay (or + 2 + TO on timeout), held until taken.
    task automatic test_random();
        int unsigned v, d, s, gap, r_cyc;
        bit          g;
        logic [3:0]  e_op, op0, op1;
        logic signed [15:0] e_a, e_b, a0, b0, a1, b1;
        logic [31:0] result, e_data;
        bit          e_err;
        for (int t = 0; t < 40; t++) begin
            gap = $urandom_range(0, 2);
            repeat (gap) begin
                @(negedge clk);
                req0_valid = 0; req1_valid = 0; unit_flag = 0;
            end
            v = $urandom_range(1, 3);
            op0 = 4'($urandom); op1 = 4'($urandom);
            a0 = 16'($urandom); b0 = 16'($urandom); a1 = 16'($urandom); b1 = 16'($urandom);
            g = (v == 3) ? ~model_last : (v == 2);
            model_last = g;
            e_op = g ? op1 : op0; e_a = g ? a1 : a0; e_b = g ? b1 : b0;
            d = $urandom_range(1, TO + 1);
            s = $urandom_range(0, 3);
            result = $urandom;
            e_err  = (d > TO);
            e_data = e_err ? 32'h0 : result;
            r_cyc  = e_err ? 2 + TO : 2 + d;
            @(negedge clk);
            req0_valid = v[0]; req0_op = op0; req0_a = a0; req0_b = b0;
            req1_valid = v[1]; req1_op = op1; req1_a = a1; req1_b = b1;
            unit_flag = 0; resp_ready = 0;
            #1;
            total++;
            if ({req0_ready, req1_ready} !== (g ? 2'b01 : 2'b10)) begin
                bad++; $display("[TB] FAIL rand_grant[%0d]: got %b want %b (valid=%0d)",
                                t, {req0_ready, req1_ready}, g ? 2'b01 : 2'b10, v);
            end
            for (int k = 1; k <= int'(r_cyc + s); k++) begin
                @(negedge clk);
                req0_valid = 0; req1_valid = 0;
                unit_flag = (k == int'(1 + d));
                unit_result = result;
                resp_ready = (k >= int'(r_cyc + s));
                #1;
                if (k == 1) begin
                    total++;
                    if ({en, alu_fun, a_out, b_out} !== {4'b0001 << e_op[3:2], e_op[1:0], e_a, e_b}) begin
                        bad++; $display("[TB] FAIL rand_issue[%0d]: got en=%b fun=%b a=%h b=%h want op=%h a=%h b=%h",
                                        t, en, alu_fun, a_out, b_out, e_op, e_a, e_b);
                    end
                end else begin
                    total++;
                    if (en !== 4'b0000) begin
                        bad++; $display("[TB] FAIL rand_en_off[%0d] cycle %0d: got %b want 0000", t, k, en);
                    end
                end
                total++;
                if (resp_valid !== (k >= int'(r_cyc))) begin
                    bad++; $display("[TB] FAIL rand_rv[%0d] cycle %0d: got %b want %b", t, k, resp_valid, k >= int'(r_cyc));
                end
                if (k >= int'(r_cyc)) begin
                    total++;
                    if ({resp_id, resp_err, resp_data} !== {g, e_err, e_data}) begin
                        bad++; $display("[TB] FAIL rand_resp[%0d]: got id=%b err=%b data=%h want id=%b err=%b data=%h",
                                        t, resp_id, resp_err, resp_data, g, e_err, e_data);
                    end
                end
            end
            unit_flag = 0;
        end
        @(negedge clk);
        resp_ready = 0;
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        test_reset();
        test_single_compare();
        test_unit_decode();
        test_contention();
        test_timeout();
        test_backpressure();
        test_reset_mid_wait();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
